// File: rtl/iwanna_soc_otg_hpi_master.sv
// Avalon-MM slave that turns each read/write into one timed CY7C67200 HPI bus cycle
// (setup, strobe, hold, turnaround), stalling the master until the hold phase ends.
module iwanna_soc_otg_hpi_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 1,
  parameter int unsigned TURN_CYC   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  otg_addr,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_TURN   = 3'd4
  } state_t;

  // The counter is loaded with N-1 on entry, so zero marks the last cycle of a state.
  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
  localparam logic [3:0] TURN_LD   = 4'(TURN_CYC - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        is_wr_q, is_wr_d;
  logic [15:0] rdreg_q, rdreg_d;

  logic request;
  logic last;
  logic active;
  logic unused_wdata_hi;

  assign request         = chipselect & (read_n ^ write_n);
  assign last            = (cnt_q == 4'd0);
  assign unused_wdata_hi = ^writedata[31:16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 2'd0;
      data_q  <= 16'd0;
      is_wr_q <= 1'b0;
      rdreg_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      is_wr_q <= is_wr_d;
      rdreg_q <= rdreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    is_wr_d = is_wr_q;
    rdreg_d = rdreg_q;
    case (state_q)
      ST_IDLE: begin
        if (request) begin
          addr_d  = address;
          data_d  = writedata[15:0];
          is_wr_d = ~write_n;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (last) begin
          cnt_d   = STROBE_LD;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_STROBE: begin
        if (last) begin
          cnt_d   = HOLD_LD;
          state_d = ST_HOLD;
          if (!is_wr_q) rdreg_d = otg_data_in;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (last) begin
          cnt_d   = TURN_LD;
          state_d = ST_TURN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_TURN: begin
        if (last) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // All HPI pins decode straight from registered state, so reset idles them immediately.
  always_comb begin
    active       = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
    otg_cs_n     = ~active;
    otg_addr     = active ? addr_q : 2'd0;
    otg_data_oe  = active & is_wr_q;
    otg_data_out = (active & is_wr_q) ? data_q : 16'd0;
    otg_rd_n     = ~((state_q == ST_STROBE) & ~is_wr_q);
    otg_wr_n     = ~((state_q == ST_STROBE) & is_wr_q);
    waitrequest  = request & ~((state_q == ST_HOLD) & last);
    readdata     = {16'd0, rdreg_q};
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_iwanna_soc_otg_hpi_master.sv
// Bench for the HPI master: two instances (default timing and S=2,T=1,H=3,TURN=1)
// checked cycle by cycle against a phase-window model derived from the cycle timing.
module tb_iwanna_soc_otg_hpi_master;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic [1:0]  cs_sel;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [15:0] din;

  logic [31:0] rdata [2];
  logic        wreq  [2];
  logic [1:0]  oaddr [2];
  logic [15:0] odata [2];
  logic        oe    [2];
  logic        ocs   [2];
  logic        ord   [2];
  logic        owr   [2];
  logic [2:0]  dbg   [2];

  int s_cyc [2] = '{1, 2};
  int t_cyc [2] = '{4, 1};
  int h_cyc [2] = '{1, 3};
  int u_cyc [2] = '{2, 1};

  logic [15:0] exp_rd [2];
  int checks = 0;
  int errors = 0;

  iwanna_soc_otg_hpi_master u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_sel[0]),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rdata[0]),
    .waitrequest(wreq[0]), .otg_addr(oaddr[0]), .otg_data_out(odata[0]),
    .otg_data_oe(oe[0]), .otg_data_in(din), .otg_cs_n(ocs[0]), .otg_rd_n(ord[0]),
    .otg_wr_n(owr[0]), .dbg_state(dbg[0])
  );

  iwanna_soc_otg_hpi_master #(
    .SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3), .TURN_CYC(1)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_sel[1]),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rdata[1]),
    .waitrequest(wreq[1]), .otg_addr(oaddr[1]), .otg_data_out(odata[1]),
    .otg_data_oe(oe[1]), .otg_data_in(din), .otg_cs_n(ocs[1]), .otg_rd_n(ord[1]),
    .otg_wr_n(owr[1]), .dbg_state(dbg[1])
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic drive_idle();
    cs_sel    = 2'b00;
    read_n    = 1'b1;
    write_n   = 1'b1;
    address   = 2'($urandom_range(0, 3));
    writedata = $urandom;
  endtask

  task automatic drive_req(input int d, input bit wr, input logic [1:0] a, input logic [15:0] wd);
    cs_sel    = 2'b00;
    cs_sel[d] = 1'b1;
    read_n    = wr;
    write_n   = ~wr;
    address   = a;
    writedata = {16'($urandom), wd};
  endtask

  // One full HPI transaction from its request cycle (k=0) through TURN. Expected pins come
  // from the phase windows: SETUP 1..S, STROBE S+1..S+T, HOLD ..L, TURN L+1..L+TURN.
  task automatic run_txn(input int d, input bit wr, input logic [1:0] a, input logic [15:0] wd,
                         input logic [15:0] rdv, input bit nxt, input bit nxt_wr,
                         input logic [1:0] nxt_a, input logic [15:0] nxt_wd, input string name);
    int s, t, l, n;
    bit act, stb, ewait;
    logic [54:0] exp_v, obs_v;
    s = s_cyc[d];
    t = t_cyc[d];
    l = s + t + h_cyc[d];
    n = l + u_cyc[d];
    for (int k = 0; k <= n; k++) begin
      if (k <= l) drive_req(d, wr, a, wd);
      else if (nxt) drive_req(d, nxt_wr, nxt_a, nxt_wd);
      else drive_idle();
      din = (k >= s + 1 && k <= s + t) ? rdv : 16'($urandom);
      @(negedge clk);
      act   = (k >= 1) && (k <= l);
      stb   = (k >= s + 1) && (k <= s + t);
      ewait = (k < l) || (k > l && nxt);
      if (k == s + t + 1 && !wr) exp_rd[d] = rdv;
      exp_v = {~act, ~(stb & ~wr), ~(stb & wr), act & wr, act ? a : 2'b00,
               (act & wr) ? wd : 16'h0000, ewait, 16'h0000, exp_rd[d]};
      obs_v = {ocs[d], ord[d], owr[d], oe[d], oaddr[d], odata[d], wreq[d], rdata[d]};
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL %s dut%0d cycle %0d {cs,rd,wr,oe,addr,dout,wait,rdata}: got %h expected %h",
                 name, d, k, obs_v, exp_v);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bit ereq;
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cs_sel    = 2'($urandom_range(0, 3));
      read_n    = 1'($urandom_range(0, 1));
      write_n   = 1'($urandom_range(0, 1));
      address   = 2'($urandom_range(0, 3));
      writedata = $urandom;
      din       = 16'($urandom);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        ereq = cs_sel[d] & (read_n ^ write_n);
        checks++;
        if ({ocs[d], ord[d], owr[d], oe[d], oaddr[d], odata[d], rdata[d], wreq[d]} !==
            {1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16'h0000, 32'h0, ereq}) begin
          errors++;
          $display("FAIL reset dut%0d: cs=%b rd=%b wr=%b oe=%b addr=%h dout=%h rdata=%h wait=%b expected idle with wait=%b",
                   d, ocs[d], ord[d], owr[d], oe[d], oaddr[d], odata[d], rdata[d], wreq[d], ereq);
        end
      end
    end
    drive_idle();
    exp_rd[0] = 16'h0;
    exp_rd[1] = 16'h0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_default();
    run_txn(0, 1'b1, 2'd2, 16'h1234, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h0, "write_default");
  endtask

  task automatic test_read_default();
    run_txn(0, 1'b0, 2'd0, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 2'd0, 16'h0, "read_default");
    // readdata must stay held through a following write
    run_txn(0, 1'b1, 2'd1, 16'h0F0F, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h0, "read_hold");
  endtask

  task automatic test_back_to_back();
    // Second request is presented during TURN; its own cycle 0 is the first's cycle 9.
    run_txn(0, 1'b1, 2'd1, 16'hA5A5, 16'h0000, 1'b1, 1'b0, 2'd3, 16'h0000, "b2b_first");
    run_txn(0, 1'b0, 2'd3, 16'h0000, 16'h5A5A, 1'b0, 1'b0, 2'd0, 16'h0, "b2b_second");
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 4; i++) begin
      cs_sel    = 2'b11;
      read_n    = 1'b0;
      write_n   = 1'b0;
      address   = 2'($urandom_range(0, 3));
      writedata = $urandom;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({ocs[d], ord[d], owr[d], oe[d], wreq[d], rdata[d]} !==
            {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, exp_rd[d]}) begin
          errors++;
          $display("FAIL illegal dut%0d cycle %0d: cs=%b rd=%b wr=%b oe=%b wait=%b rdata=%h expected idle pins, wait=0, rdata=%h",
                   d, i, ocs[d], ord[d], owr[d], oe[d], wreq[d], rdata[d], exp_rd[d]);
        end
      end
      @(posedge clk);
      #1;
    end
    drive_idle();
  endtask

  task automatic test_params();
    run_txn(1, 1'b0, 2'd3, 16'h0000, 16'hC0DE, 1'b1, 1'b1, 2'd2, 16'h7E57, "params_first");
    run_txn(1, 1'b1, 2'd2, 16'h7E57, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h0, "params_second");
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k <= 3; k++) begin
      drive_req(0, 1'b1, 2'd1, 16'h4321);
      @(negedge clk);
      if (k < 3) begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if ({ocs[0], owr[0]} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_pre: cs=%b wr=%b expected 0 0", ocs[0], owr[0]);
    end
    #2 reset_n = 1'b0;
    #1;
    exp_rd[0] = 16'h0;
    exp_rd[1] = 16'h0;
    checks++;
    if ({ocs[0], ord[0], owr[0], oe[0], oaddr[0], odata[0], rdata[0], rdata[1]} !==
        {1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 16'h0000, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL mid_reset_async: cs=%b rd=%b wr=%b oe=%b addr=%h dout=%h rdata0=%h rdata1=%h expected idle and zero",
               ocs[0], ord[0], owr[0], oe[0], oaddr[0], odata[0], rdata[0], rdata[1]);
    end
    drive_idle();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_txn(0, 1'b0, 2'd1, 16'h0000, 16'h9A3C, 1'b0, 1'b0, 2'd0, 16'h0, "post_reset_read");
  endtask

  task automatic test_random();
    bit pend, p_wr, c_wr, nxt, n_wr;
    logic [1:0] p_a, c_a, n_a;
    logic [15:0] p_wd, c_wd, n_wd;
    int d;
    pend = 1'b0;
    p_wr = 1'b0;
    p_a  = 2'd0;
    p_wd = 16'h0;
    d    = 0;
    for (int i = 0; i < 12; i++) begin
      if (pend) begin
        c_wr = p_wr;
        c_a  = p_a;
        c_wd = p_wd;
      end else begin
        d    = $urandom_range(0, 1);
        c_wr = 1'($urandom_range(0, 1));
        c_a  = 2'($urandom_range(0, 3));
        c_wd = 16'($urandom);
      end
      nxt  = (i < 11) ? 1'($urandom_range(0, 1)) : 1'b0;
      n_wr = 1'($urandom_range(0, 1));
      n_a  = 2'($urandom_range(0, 3));
      n_wd = 16'($urandom);
      run_txn(d, c_wr, c_a, c_wr ? c_wd : 16'h0, 16'($urandom), nxt, n_wr, n_a,
              n_wr ? n_wd : 16'h0, "random");
      pend = nxt;
      p_wr = n_wr;
      p_a  = n_a;
      p_wd = n_wr ? n_wd : 16'h0;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    din       = 16'h0;
    exp_rd[0] = 16'h0;
    exp_rd[1] = 16'h0;
    drive_idle();
    @(posedge clk);
    #1;
    test_reset();
    test_write_default();
    test_read_default();
    test_back_to_back();
    test_illegal();
    test_params();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
